// File: rtl/hdmi_video_timing.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_video_timing
//  Purpose  : Raster timing generator (hsync, vsync, de, x/y) for the ADV7513
//             parallel video input. Defaults to CEA-861 1280x720p60.
//  Revision : 1.0  - initial release
// ============================================================================
module hdmi_video_timing #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        running,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit window bounds so an end value of 4096 is still representable
    localparam logic [11:0] c_H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] c_V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] c_H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] c_V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] c_HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] c_HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] c_VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] c_VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic        r_frame_start;
    logic        r_running;
    logic [15:0] r_frame_count;

    state_t      w_state_nxt;
    logic        w_x_last;
    logic        w_last;
    logic        w_active_nxt;
    logic [11:0] w_x_nxt;
    logic [11:0] w_y_nxt;
    logic        w_hsync_nxt;
    logic        w_vsync_nxt;
    logic        w_de_nxt;
    logic        w_fs_nxt;
    logic [15:0] w_fc_nxt;

    // Next-state and next-output computation; outputs are derived from the
    // next position so that they register coherently with x and y.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_last     = (r_x == c_H_LAST);
        w_last       = w_x_last && (r_y == c_V_LAST);
        w_x_nxt      = 12'd0;
        w_y_nxt      = 12'd0;
        w_fc_nxt     = r_frame_count;

        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Enable falling on the last pixel ends the frame right here
                if (!enable) w_state_nxt = w_last ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (enable)      w_state_nxt = S_RUN;
                else if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_active_nxt = (w_state_nxt != S_IDLE);

        // Raster advance only while already producing; entry from IDLE is (0,0)
        if (r_state != S_IDLE) begin
            if (w_last) w_fc_nxt = r_frame_count + 16'd1;
            if (w_active_nxt) begin
                w_x_nxt = w_x_last ? 12'd0 : r_x + 12'd1;
                if (w_x_last) w_y_nxt = (r_y == c_V_LAST) ? 12'd0 : r_y + 12'd1;
                else          w_y_nxt = r_y;
            end
        end

        w_de_nxt    = w_active_nxt && ({1'b0, w_x_nxt} < c_H_ACT)
                                   && ({1'b0, w_y_nxt} < c_V_ACT);
        w_hsync_nxt = (w_active_nxt && ({1'b0, w_x_nxt} >= c_HS_START)
                                    && ({1'b0, w_x_nxt} <  c_HS_END)) ? HS_POL : ~HS_POL;
        w_vsync_nxt = (w_active_nxt && ({1'b0, w_y_nxt} >= c_VS_START)
                                    && ({1'b0, w_y_nxt} <  c_VS_END)) ? VS_POL : ~VS_POL;
        w_fs_nxt    = w_active_nxt && (w_x_nxt == 12'd0) && (w_y_nxt == 12'd0);
    end

    // State and output registers; reset returns everything to inactive levels
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_x           <= 12'd0;
            r_y           <= 12'd0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_de          <= w_de_nxt;
            r_frame_start <= w_fs_nxt;
            r_running     <= w_active_nxt;
            r_frame_count <= w_fc_nxt;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;
    assign running     = r_running;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hdmi_video_timing
//  Purpose  : Directed self-checking bench for hdmi_video_timing using a
//             16x8 raster; a second instance checks inverted sync polarity.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_hdmi_video_timing;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;

    logic        hs_p, vs_p, de_p, fs_p, run_p;
    logic [11:0] x_p, y_p;
    logic [15:0] fc_p;
    logic        hs_n, vs_n, de_n, fs_n, run_n;
    logic [11:0] x_n, y_n;
    logic [15:0] fc_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hdmi_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .hsync(hs_p), .vsync(vs_p), .de(de_p), .x(x_p), .y(y_p),
        .frame_start(fs_p), .running(run_p), .frame_count(fc_p)
    );

    hdmi_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_n (
        .clk(clk), .reset(reset), .enable(enable),
        .hsync(hs_n), .vsync(vs_n), .de(de_n), .x(x_n), .y(y_n),
        .frame_start(fs_n), .running(run_n), .frame_count(fc_n)
    );

    typedef struct {
        bit en;
        int n;
        int ex;
        int ey;
        bit de;
        bit hs;
        bit vs;
        bit fs;
        bit run;
        int fc;
    } vec_t;

    vec_t tbl[12];

    // Advance n rising edges, then settle 1 time unit before sampling
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // hs/vs arguments are "sync asserted"; the inverted instance must show the opposite level
    task automatic check_all(input string tag, input int ex, input int ey, input bit ede,
                             input bit ehs, input bit evs, input bit efs, input bit erun,
                             input int efc);
        chk({tag, " x"}, 32'(x_p), ex);
        chk({tag, " y"}, 32'(y_p), ey);
        chk({tag, " de"}, 32'(de_p), 32'(ede));
        chk({tag, " hsync"}, 32'(hs_p), 32'(ehs));
        chk({tag, " vsync"}, 32'(vs_p), 32'(evs));
        chk({tag, " frame_start"}, 32'(fs_p), 32'(efs));
        chk({tag, " running"}, 32'(run_p), 32'(erun));
        chk({tag, " frame_count"}, 32'(fc_p), efc);
        chk({tag, " hsync_n"}, 32'(hs_n), 32'(!ehs));
        chk({tag, " vsync_n"}, 32'(vs_n), 32'(!evs));
        chk({tag, " de_n"}, 32'(de_n), 32'(ede));
    endtask

    initial begin
        int cnt_vs, cnt_fs, cnt_pol, gaps;

        // Checkpoints from the first RUN cycle t=0: x=t%16, y=(t/16)%8, fc=t/128
        tbl[0]  = '{1, 7,   7, 0, 1, 0, 0, 0, 1, 0};  // t=7 last active pixel
        tbl[1]  = '{1, 1,   8, 0, 0, 0, 0, 0, 1, 0};  // t=8 front porch
        tbl[2]  = '{1, 2,  10, 0, 0, 1, 0, 0, 1, 0};  // t=10 hsync start
        tbl[3]  = '{1, 2,  12, 0, 0, 1, 0, 0, 1, 0};  // t=12 hsync last
        tbl[4]  = '{1, 1,  13, 0, 0, 0, 0, 0, 1, 0};  // t=13 hsync off
        tbl[5]  = '{1, 2,  15, 0, 0, 0, 0, 0, 1, 0};  // t=15 end of line
        tbl[6]  = '{1, 1,   0, 1, 1, 0, 0, 0, 1, 0};  // t=16 line wrap
        tbl[7]  = '{1, 64,  0, 5, 0, 0, 1, 0, 1, 0};  // t=80 vsync start
        tbl[8]  = '{1, 31, 15, 6, 0, 0, 1, 0, 1, 0};  // t=111 vsync last pixel
        tbl[9]  = '{1, 1,   0, 7, 0, 0, 0, 0, 1, 0};  // t=112 vsync off
        tbl[10] = '{1, 16,  0, 0, 1, 0, 0, 1, 1, 1};  // t=128 frame 1
        tbl[11] = '{1, 128, 0, 0, 1, 0, 0, 1, 1, 2};  // t=256 frame 2

        reset  = 1'b1;
        enable = 1'b0;
        step(3);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        step(6);
        check_all("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        enable = 1'b1;
        step(1);
        check_all("start", 0, 0, 1, 0, 0, 1, 1, 0);

        for (int i = 0; i < 12; i++) begin
            enable = tbl[i].en;
            step(tbl[i].n);
            check_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].de,
                      tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].run, tbl[i].fc);
        end

        // One full line from t=256: de on x<8, hsync only on x=10..12
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("line x%0d x", i), 32'(x_p), i);
            chk($sformatf("line x%0d de", i), 32'(de_p), 32'(i < 8));
            chk($sformatf("line x%0d hsync", i), 32'(hs_p), 32'(i >= 10 && i <= 12));
            step(1);
        end

        // 128 cycles from t=272: vsync covers two lines, one frame_start pulse
        cnt_vs = 0; cnt_fs = 0; cnt_pol = 0;
        for (int i = 0; i < 128; i++) begin
            if (vs_p) cnt_vs++;
            if (fs_p) cnt_fs++;
            if (vs_n == vs_p) cnt_pol++;
            step(1);
        end
        chk("vsync cycles per frame", 32'(cnt_vs), 32);
        chk("frame_start pulses per frame", 32'(cnt_fs), 1);
        chk("vsync polarity agreement", 32'(cnt_pol), 0);

        // Drain: drop enable at (3,2) of frame 3, frame must run out to (15,7)
        step(19);
        check_all("drain at", 3, 2, 1, 0, 0, 0, 1, 3);
        enable = 1'b0;
        step(92);
        check_all("drain last", 15, 7, 0, 0, 0, 0, 1, 3);
        step(1);
        check_all("drain idle", 0, 0, 0, 0, 0, 0, 0, 4);

        // Re-raise during drain at y=6: no IDLE gap, next frame on schedule
        enable = 1'b1;
        step(1);
        check_all("restart", 0, 0, 1, 0, 0, 1, 1, 4);
        enable = 1'b0;
        gaps = 0;
        for (int i = 0; i < 96; i++) begin
            step(1);
            if (!run_p) gaps++;
        end
        check_all("reraise at", 0, 6, 0, 0, 1, 0, 1, 4);
        enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(1);
            if (!run_p) gaps++;
        end
        check_all("reraise frame", 0, 0, 1, 0, 0, 1, 1, 5);
        chk("reraise running gaps", 32'(gaps), 0);

        // Reset mid-frame at (5,3)
        step(53);
        check_all("pre reset", 5, 3, 1, 0, 0, 0, 1, 5);
        reset = 1'b1;
        step(1);
        check_all("mid reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // Enable falling exactly on the last pixel goes straight to IDLE
        reset = 1'b0;
        step(1);
        check_all("restart2", 0, 0, 1, 0, 0, 1, 1, 0);
        step(127);
        check_all("last pixel", 15, 7, 0, 0, 0, 0, 1, 0);
        enable = 1'b0;
        step(1);
        check_all("last drop idle", 0, 0, 0, 0, 0, 0, 0, 1);
        step(3);
        check_all("stay idle", 0, 0, 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
